slave_reg: RTL and testbench

// - Bus responder (slave end) of the two-phase valid/ready bus: register file of NUM_REGS x 32b words.
// - Completes ADDR then DATA phases started by the bus master.
// - Applies writes, returns reads, flags illegal accesses.
// - Exposes register contents and per-register write strobes to downstream logic.

---
 rtl/bus_pkg.sv | 19 +
 rtl/bus_if.sv | 29 ++
 rtl/slave_regfile.sv | 69 ++++++
 rtl/slave_reg.sv | 116 +++++++++++
 tb/tb_slave_reg.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared widths and phase encoding for the two-phase
//               valid/ready bus, used by both master and slave ends.
// Revision    : 1.0
// ============================================================================
package bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_ADDR_PHASE = 2'd0,
        ST_DATA_PHASE = 2'd1
    } bus_state_t;

endpackage
`default_nettype wire

// File: rtl/bus_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_if
// Description : Two-phase valid/ready bus bundle with master/slave views.
// Revision    : 1.0
// ============================================================================
interface bus_if;
    import bus_pkg::*;

    logic              valid;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic              ready;
    logic [DATA_W-1:0] read_data;

    modport master (
        output valid, read, write, addr, write_data,
        input  ready, read_data
    );

    modport slave (
        input  valid, read, write, addr, write_data,
        output ready, read_data
    );

endinterface
`default_nettype wire

// File: rtl/slave_regfile.sv
`default_nettype none
// ============================================================================
// Module      : slave_regfile
// Description : NUM_REGS x 32b storage with one synchronous write port,
//               a combinational read mux and per-register write strobes.
// Revision    : 1.0
// ============================================================================
module slave_regfile
    import bus_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            wr_idx,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [ADDR_W-1:0]            rd_idx,
    output logic [DATA_W-1:0]            rd_data,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic [NUM_REGS-1:0]          wr_strobe
);

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [DATA_W-1:0]   mem_d [NUM_REGS];
    logic [NUM_REGS-1:0] strobe_q;
    logic [NUM_REGS-1:0] strobe_d;

    always_comb begin
        mem_d    = mem_q;
        strobe_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (we && (wr_idx == ADDR_W'(i))) begin
                mem_d[i]    = wr_data;
                strobe_d[i] = 1'b1;
            end
        end
    end

    // Out-of-range indices read as zero; the caller masks them anyway.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == ADDR_W'(i)) begin
                rd_data = mem_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
            strobe_q <= '0;
        end else begin
            mem_q    <= mem_d;
            strobe_q <= strobe_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
        assign regs_o[g*DATA_W +: DATA_W] = mem_q[g];
    end

    assign wr_strobe = strobe_q;

endmodule
`default_nettype wire

// File: rtl/slave_reg.sv
`default_nettype none
// ============================================================================
// Module      : slave_reg
// Description : Slave end of the two-phase valid/ready bus fronting a
//               NUM_REGS x 32b register file.
// Revision    : 1.0
// ============================================================================
module slave_reg
    import bus_pkg::*;
#(
    parameter int              NUM_REGS    = 16,
    parameter logic [15:0]     BASE_ADDR   = 16'h0000,
    parameter int              WAIT_CYCLES = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    bus_if.slave                         busa,
    output logic                         err,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic [NUM_REGS-1:0]          wr_strobe
);

    localparam logic [3:0]        c_wait_max = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W:0]   c_num_regs = (ADDR_W+1)'(NUM_REGS);

    bus_state_t        state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              is_wr_q, is_wr_d;
    logic              err_r_q, err_r_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;

    logic              w_ready;
    logic              w_hs;
    logic              w_addr_hs;
    logic              w_data_hs;
    logic [ADDR_W-1:0] w_idx;
    logic              w_err;
    logic              w_we;
    logic [DATA_W-1:0] w_rd_data;

    assign w_ready   = busa.valid && (wait_cnt_q == c_wait_max) && !reset;
    assign w_hs      = busa.valid && w_ready;
    assign w_addr_hs = w_hs && (state_q == ST_ADDR_PHASE);
    assign w_data_hs = w_hs && (state_q == ST_DATA_PHASE);
    assign w_idx     = busa.addr - BASE_ADDR;
    assign w_err     = ({1'b0, w_idx} >= c_num_regs) || (busa.read == busa.write);
    assign w_we      = w_data_hs && is_wr_q && !err_r_q;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        idx_d       = idx_q;
        is_wr_d     = is_wr_q;
        err_r_d     = err_r_q;
        read_data_d = read_data_q;

        case (state_q)
            ST_ADDR_PHASE: if (w_hs) state_d = ST_DATA_PHASE;
            // Dropping valid mid-data-phase abandons the transfer.
            ST_DATA_PHASE: if (w_hs || !busa.valid) state_d = ST_ADDR_PHASE;
            default:       state_d = ST_ADDR_PHASE;
        endcase

        if (w_hs || ((state_q == ST_ADDR_PHASE) && !busa.valid) || (state_d != state_q)) begin
            wait_cnt_d = '0;
        end else if (busa.valid && !w_ready && (wait_cnt_q < c_wait_max)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        if (w_addr_hs) begin
            idx_d       = w_idx;
            is_wr_d     = busa.write;
            err_r_d     = w_err;
            read_data_d = (busa.read && !w_err) ? w_rd_data : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ADDR_PHASE;
            wait_cnt_q  <= '0;
            idx_q       <= '0;
            is_wr_q     <= 1'b0;
            err_r_q     <= 1'b0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            idx_q       <= idx_d;
            is_wr_q     <= is_wr_d;
            err_r_q     <= err_r_d;
            read_data_q <= read_data_d;
        end
    end

    slave_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .we        (w_we),
        .wr_idx    (idx_q),
        .wr_data   (busa.write_data),
        .rd_idx    (w_idx),
        .rd_data   (w_rd_data),
        .regs_o    (regs_o),
        .wr_strobe (wr_strobe)
    );

    assign busa.ready     = w_ready;
    assign busa.read_data = read_data_q;
    assign err            = err_r_q && w_ready && (state_q == ST_DATA_PHASE);

endmodule
`default_nettype wire

// File: tb/tb_slave_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_slave_reg
// Description : Directed, table-driven bench for slave_reg at two wait settings.
// Revision    : 1.0
// ============================================================================
module tb_slave_reg;
    import bus_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bus_if bus0();
    bus_if bus2();

    logic         err0, err2;
    logic [511:0] regs0, regs2;
    logic [15:0]  strobe0, strobe2;

    slave_reg #(.NUM_REGS(16), .BASE_ADDR(16'h0000), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .busa(bus0), .err(err0), .regs_o(regs0), .wr_strobe(strobe0)
    );

    slave_reg #(.NUM_REGS(16), .BASE_ADDR(16'h0000), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .reset(reset), .busa(bus2), .err(err2), .regs_o(regs2), .wr_strobe(strobe2)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [15:0] exp_stb;
    } vec_t;

    vec_t        vecs [12];
    logic [31:0] model [16];
    logic [511:0] model_flat;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_wide(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int sel, input logic v, input logic rd, input logic wr,
                           input logic [15:0] addr, input logic [31:0] wd);
        if (sel == 0) begin
            bus0.valid = v; bus0.read = rd; bus0.write = wr; bus0.addr = addr; bus0.write_data = wd;
        end else begin
            bus2.valid = v; bus2.read = rd; bus2.write = wr; bus2.addr = addr; bus2.write_data = wd;
        end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? bus0.ready : bus2.ready;
    endfunction
    function automatic logic [31:0] get_rdata(input int sel);
        return (sel == 0) ? bus0.read_data : bus2.read_data;
    endfunction
    function automatic logic get_err(input int sel);
        return (sel == 0) ? err0 : err2;
    endfunction
    function automatic logic [15:0] get_strobe(input int sel);
        return (sel == 0) ? strobe0 : strobe2;
    endfunction

    // One full ADDR+DATA transfer; inputs change on negedge, outputs sampled 1ns later.
    task automatic xfer(input int sel, input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [31:0] wd, output int wa, output int wdc,
                        output logic [31:0] rdata, output logic err,
                        output logic [15:0] stb, output logic [15:0] stb_after);
        @(negedge clk);
        set_req(sel, 1'b1, rd, wr, addr, wd);
        #1;
        wa = 0;
        while (!get_ready(sel) && wa < 20) begin
            @(negedge clk); #1; wa++;
        end
        @(negedge clk); #1;
        wdc = 0;
        while (!get_ready(sel) && wdc < 20) begin
            @(negedge clk); #1; wdc++;
        end
        rdata = get_rdata(sel);
        err   = get_err(sel);
        @(negedge clk);
        set_req(sel, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        #1;
        stb = get_strobe(sel);
        @(negedge clk); #1;
        stb_after = get_strobe(sel);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          wa, wdc;
        logic [31:0] rdata;
        logic        err;
        logic [15:0] stb, stb_after;

        vecs[0]  = '{1'b0, 1'b1, 16'h0001, 32'hDEACBEFF, 32'h0,        1'b0, 16'h0002};
        vecs[1]  = '{1'b1, 1'b0, 16'h0001, 32'h0,        32'hDEACBEFF, 1'b0, 16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 16'h0005, 32'h12345678, 32'h0,        1'b0, 16'h0020};
        vecs[3]  = '{1'b0, 1'b1, 16'h0010, 32'hFFFFFFFF, 32'h0,        1'b1, 16'h0000};
        vecs[4]  = '{1'b1, 1'b1, 16'h0000, 32'h55555555, 32'h0,        1'b1, 16'h0000};
        vecs[5]  = '{1'b1, 1'b0, 16'h0005, 32'h0,        32'h12345678, 1'b0, 16'h0000};
        vecs[6]  = '{1'b0, 1'b0, 16'h0002, 32'hABABABAB, 32'h0,        1'b1, 16'h0000};
        vecs[7]  = '{1'b0, 1'b1, 16'h000F, 32'hA5A5A5A5, 32'h0,        1'b0, 16'h8000};
        vecs[8]  = '{1'b1, 1'b0, 16'h000F, 32'h0,        32'hA5A5A5A5, 1'b0, 16'h0000};
        vecs[9]  = '{1'b1, 1'b0, 16'hFFFF, 32'h0,        32'h0,        1'b1, 16'h0000};
        vecs[10] = '{1'b0, 1'b1, 16'h0000, 32'h00000001, 32'h0,        1'b0, 16'h0001};
        vecs[11] = '{1'b1, 1'b0, 16'h0000, 32'h0,        32'h00000001, 1'b0, 16'h0000};
        for (int i = 0; i < 16; i++) model[i] = 32'h0;

        set_req(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        repeat (3) @(negedge clk);
        set_req(0, 1'b1, 1'b0, 1'b1, 16'h0001, 32'h0);
        #1;
        chk("ready_during_reset", 64'(get_ready(0)), 64'd0);
        set_req(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ready", 64'(bus0.ready), 64'd0);
        chk("rst_rdata", 64'(bus0.read_data), 64'd0);
        chk("rst_err", 64'(err0), 64'd0);
        chk("rst_strobe", 64'(strobe0), 64'd0);
        chk_wide("rst_regs0", regs0, 512'd0);
        chk_wide("rst_regs2", regs2, 512'd0);

        for (int i = 0; i < 12; i++) begin
            xfer(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, wa, wdc, rdata, err, stb, stb_after);
            chk($sformatf("v%0d_addr_wait", i), 64'(wa), 64'd0);
            chk($sformatf("v%0d_data_wait", i), 64'(wdc), 64'd0);
            chk($sformatf("v%0d_rdata", i), 64'(rdata), 64'(vecs[i].exp_rd));
            chk($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
            chk($sformatf("v%0d_strobe", i), 64'(stb), 64'(vecs[i].exp_stb));
            chk($sformatf("v%0d_strobe_after", i), 64'(stb_after), 64'd0);
            if (vecs[i].wr && !vecs[i].rd && vecs[i].addr < 16'd16) model[vecs[i].addr[3:0]] = vecs[i].wd;
        end
        for (int i = 0; i < 16; i++) model_flat[i*32 +: 32] = model[i];
        chk_wide("regs_after_table", regs0, model_flat);

        // Wait-state DUT: ready on the 3rd valid cycle of each phase.
        xfer(1, 1'b0, 1'b1, 16'h0003, 32'hCAFEF00D, wa, wdc, rdata, err, stb, stb_after);
        chk("w2_wr_addr_wait", 64'(wa), 64'd2);
        chk("w2_wr_data_wait", 64'(wdc), 64'd2);
        chk("w2_wr_err", 64'(err), 64'd0);
        chk("w2_wr_strobe", 64'(stb), 64'h0008);
        chk("w2_wr_strobe_after", 64'(stb_after), 64'd0);
        chk("w2_reg3", 64'(regs2[3*32 +: 32]), 64'hCAFEF00D);
        xfer(1, 1'b1, 1'b0, 16'h0003, 32'h0, wa, wdc, rdata, err, stb, stb_after);
        chk("w2_rd_addr_wait", 64'(wa), 64'd2);
        chk("w2_rd_data_wait", 64'(wdc), 64'd2);
        chk("w2_rd_rdata", 64'(rdata), 64'hCAFEF00D);
        xfer(1, 1'b1, 1'b1, 16'h0000, 32'h0, wa, wdc, rdata, err, stb, stb_after);
        chk("w2_err_data_wait", 64'(wdc), 64'd2);
        chk("w2_err", 64'(err), 64'd1);
        chk("w2_err_rdata", 64'(rdata), 64'd0);

        // Abort: valid drops in the data phase of a write.
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 1'b1, 16'h0007, 32'h11111111);
        #1;
        chk("abort_addr_ready", 64'(bus0.ready), 64'd1);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        #1;
        chk("abort_data_ready", 64'(bus0.ready), 64'd0);
        @(negedge clk); #1;
        chk("abort_strobe", 64'(strobe0), 64'd0);
        chk("abort_reg7", 64'(regs0[7*32 +: 32]), 64'd0);
        xfer(0, 1'b1, 1'b0, 16'h0007, 32'hFFFFFFFF, wa, wdc, rdata, err, stb, stb_after);
        chk("after_abort_rdata", 64'(rdata), 64'd0);
        chk("after_abort_err", 64'(err), 64'd0);
        chk("after_abort_strobe", 64'(stb), 64'd0);
        chk("after_abort_reg7", 64'(regs0[7*32 +: 32]), 64'd0);

        // Reset in the data phase of a write.
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 1'b1, 16'h0009, 32'h99999999);
        #1;
        chk("rstmid_addr_ready", 64'(bus0.ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstmid_ready", 64'(bus0.ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        set_req(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        #1;
        chk_wide("rstmid_regs", regs0, 512'd0);
        chk("rstmid_rdata", 64'(bus0.read_data), 64'd0);
        chk("rstmid_strobe", 64'(strobe0), 64'd0);
        xfer(0, 1'b0, 1'b1, 16'h0009, 32'h99999999, wa, wdc, rdata, err, stb, stb_after);
        chk("post_rst_wr_wait", 64'(wa + wdc), 64'd0);
        chk("post_rst_wr_strobe", 64'(stb), 64'h0200);
        xfer(0, 1'b1, 1'b0, 16'h0009, 32'h0, wa, wdc, rdata, err, stb, stb_after);
        chk("post_rst_rdata", 64'(rdata), 64'h99999999);
        chk("post_rst_err", 64'(err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
